// File: rtl/ref_force_wb_arbiter_pkg.sv
// Shared types and constants for the reference-force writeback path (package md_wb_pkg).
package md_wb_pkg;
    localparam int DATA_WIDTH        = 32;
    localparam int PARTICLE_ID_WIDTH = 20;
    localparam int CELL_ID_WIDTH     = 3;
    localparam int NUM_ACC           = 7;
    localparam int ID_WIDTH          = 3 * CELL_ID_WIDTH + PARTICLE_ID_WIDTH;
    localparam int LANE_WIDTH        = 3;

    localparam logic [CELL_ID_WIDTH-1:0] CELL_1 = 3'd1;
    localparam logic [CELL_ID_WIDTH-1:0] CELL_2 = 3'd2;
    localparam logic [CELL_ID_WIDTH-1:0] CELL_3 = 3'd3;

    typedef struct packed {
        logic [CELL_ID_WIDTH-1:0]     cell_x;
        logic [CELL_ID_WIDTH-1:0]     cell_y;
        logic [CELL_ID_WIDTH-1:0]     cell_z;
        logic [PARTICLE_ID_WIDTH-1:0] particle;
    } full_id_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
        logic [DATA_WIDTH-1:0] z;
    } force_vec_t;

    typedef enum logic [1:0] {
        BATCH_IDLE   = 2'd0,
        BATCH_ACTIVE = 2'd1,
        BATCH_DONE   = 2'd2
    } batch_state_t;

    // Folds a lane sum in 0..12 back into 0..6.
    function automatic logic [LANE_WIDTH-1:0] lane_wrap(input logic [LANE_WIDTH:0] v);
        if (v >= 4'(NUM_ACC)) begin
            return LANE_WIDTH'(v - 4'(NUM_ACC));
        end else begin
            return v[LANE_WIDTH-1:0];
        end
    endfunction
endpackage

// File: rtl/ref_force_wb_arbiter_if.sv
// Accumulator-bank input lanes and force-cache writeback port of ref_force_wb_arbiter.
interface ref_force_wb_arbiter_if;
    import md_wb_pkg::*;

    logic [NUM_ACC-1:0]                 in_valid;
    logic [NUM_ACC-1:0]                 in_start_wb;
    logic [NUM_ACC-1:0][ID_WIDTH-1:0]   in_id;
    logic [NUM_ACC-1:0][DATA_WIDTH-1:0] in_force_x;
    logic [NUM_ACC-1:0][DATA_WIDTH-1:0] in_force_y;
    logic [NUM_ACC-1:0][DATA_WIDTH-1:0] in_force_z;
    logic                               out_wb_valid;
    logic                               out_wb_ready;
    logic [ID_WIDTH-1:0]                out_wb_id;
    logic [DATA_WIDTH-1:0]              out_wb_force_x;
    logic [DATA_WIDTH-1:0]              out_wb_force_y;
    logic [DATA_WIDTH-1:0]              out_wb_force_z;
    logic [LANE_WIDTH-1:0]              out_wb_lane;
    logic                               out_busy;
    logic                               out_batch_done;
    logic [2:0]                         out_batch_count;
    logic                               out_overflow;

    modport master (
        output in_valid, in_start_wb, in_id, in_force_x, in_force_y, in_force_z, out_wb_ready,
        input  out_wb_valid, out_wb_id, out_wb_force_x, out_wb_force_y, out_wb_force_z,
        input  out_wb_lane, out_busy, out_batch_done, out_batch_count, out_overflow
    );

    modport slave (
        input  in_valid, in_start_wb, in_id, in_force_x, in_force_y, in_force_z, out_wb_ready,
        output out_wb_valid, out_wb_id, out_wb_force_x, out_wb_force_y, out_wb_force_z,
        output out_wb_lane, out_busy, out_batch_done, out_batch_count, out_overflow
    );
endinterface

// File: rtl/ref_force_wb_arbiter_rr.sv
// wb_rr_arbiter: round-robin grant over seven requesters; pointer moves past the winner on advance.
module wb_rr_arbiter
    import md_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_ACC-1:0]    request,
    input  logic                  advance,
    output logic [NUM_ACC-1:0]    grant,
    output logic [LANE_WIDTH-1:0] grant_idx,
    output logic                  grant_valid
);
    logic [LANE_WIDTH-1:0] rr_ptr_r;
    logic [LANE_WIDTH-1:0] idx_s;

    // Scan downward so the requester nearest the pointer is the last one written.
    always_comb begin
        idx_s       = 3'd0;
        grant_idx   = 3'd0;
        grant_valid = 1'b0;
        for (int k = NUM_ACC - 1; k >= 0; k--) begin
            idx_s = lane_wrap({1'b0, rr_ptr_r} + 4'(k));
            if (request[idx_s]) begin
                grant_idx   = idx_s;
                grant_valid = 1'b1;
            end else begin
                grant_idx   = grant_idx;
                grant_valid = grant_valid;
            end
        end
        grant = grant_valid ? 7'(7'd1 << grant_idx) : 7'd0;
    end

    // Round-robin pointer update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= 3'd0;
        end else if (advance && grant_valid) begin
            rr_ptr_r <= lane_wrap({1'b0, grant_idx} + 4'd1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
endmodule

// File: rtl/ref_force_wb_arbiter.sv
// Seven-lane reference-force writeback arbiter with batch tracking.
// Optional overflow detection is enabled by defining REF_WB_OVERFLOW_CHECK_EN.
module ref_force_wb_arbiter
    import md_wb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    ref_force_wb_arbiter_if.slave  bus
);
    logic [NUM_ACC-1:0]               pending_r;
    full_id_t [NUM_ACC-1:0]           slot_id_r;
    force_vec_t [NUM_ACC-1:0]         slot_force_r;
    logic                             wb_valid_r;
    full_id_t                         wb_id_r;
    force_vec_t                       wb_force_r;
    logic [LANE_WIDTH-1:0]            wb_lane_r;
    batch_state_t                     state_r;
    logic [2:0]                       batch_cnt_r;
    logic                             batch_done_r;
    logic [2:0]                       batch_count_r;
    logic [NUM_ACC-1:0]               grant_s;
    logic [LANE_WIDTH-1:0]            grant_idx_s;
    logic                             grant_valid_s;
    logic                             advance_s;
    logic                             fire_s;
    logic                             handshake_s;
    logic                             drained_s;

    assign advance_s   = ~wb_valid_r | bus.out_wb_ready;
    assign fire_s      = advance_s & grant_valid_s;
    assign handshake_s = wb_valid_r & bus.out_wb_ready;
    assign drained_s   = ~(|pending_r) & ~wb_valid_r & ~(|bus.in_valid);

    wb_rr_arbiter u_arb (
        .clk         (clk),
        .rst         (rst),
        .request     (pending_r),
        .advance     (advance_s),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Holding slots: a capture wins over a same-edge grant, so pending stays set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r    <= '0;
            slot_id_r    <= '0;
            slot_force_r <= '0;
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (bus.in_valid[i]) begin
                    pending_r[i]    <= 1'b1;
                    slot_id_r[i]    <= bus.in_id[i];
                    slot_force_r[i] <= {bus.in_force_x[i], bus.in_force_y[i], bus.in_force_z[i]};
                end else if (fire_s && grant_s[i]) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Output word register; fields only change on a grant, so they hold during backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_r <= 1'b0;
            wb_id_r    <= '0;
            wb_force_r <= '0;
            wb_lane_r  <= 3'd0;
        end else if (fire_s) begin
            wb_valid_r <= 1'b1;
            wb_id_r    <= slot_id_r[grant_idx_s];
            wb_force_r <= slot_force_r[grant_idx_s];
            wb_lane_r  <= grant_idx_s;
        end else if (bus.out_wb_ready) begin
            wb_valid_r <= 1'b0;
        end else begin
            wb_valid_r <= wb_valid_r;
        end
    end

    // Batch tracking FSM with registered completion pulse and count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= BATCH_IDLE;
            batch_cnt_r   <= 3'd0;
            batch_done_r  <= 1'b0;
            batch_count_r <= 3'd0;
        end else begin
            case (state_r)
                BATCH_IDLE: begin
                    batch_done_r <= 1'b0;
                    if (|bus.in_start_wb) begin
                        state_r     <= BATCH_ACTIVE;
                        batch_cnt_r <= 3'd0;
                    end else begin
                        state_r <= BATCH_IDLE;
                    end
                end
                BATCH_ACTIVE: begin
                    if (handshake_s && (batch_cnt_r != 3'd7)) begin
                        batch_cnt_r <= batch_cnt_r + 3'd1;
                    end else begin
                        batch_cnt_r <= batch_cnt_r;
                    end
                    if (drained_s) begin
                        state_r       <= BATCH_DONE;
                        batch_done_r  <= 1'b1;
                        batch_count_r <= batch_cnt_r;
                    end else begin
                        state_r      <= BATCH_ACTIVE;
                        batch_done_r <= 1'b0;
                    end
                end
                BATCH_DONE: begin
                    state_r      <= BATCH_IDLE;
                    batch_done_r <= 1'b0;
                end
                default: begin
                    state_r      <= BATCH_IDLE;
                    batch_done_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef REF_WB_OVERFLOW_CHECK_EN
    logic               overflow_r;
    logic [NUM_ACC-1:0] ovf_s;

    assign ovf_s = bus.in_valid & pending_r & ~({NUM_ACC{fire_s}} & grant_s);

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | (|ovf_s);
        end
    end

    assign bus.out_overflow = overflow_r;
`else
    assign bus.out_overflow = 1'b0;
`endif

    assign bus.out_wb_valid    = wb_valid_r;
    assign bus.out_wb_id       = wb_id_r;
    assign bus.out_wb_force_x  = wb_force_r.x;
    assign bus.out_wb_force_y  = wb_force_r.y;
    assign bus.out_wb_force_z  = wb_force_r.z;
    assign bus.out_wb_lane     = wb_lane_r;
    assign bus.out_busy        = (|pending_r) | wb_valid_r;
    assign bus.out_batch_done  = batch_done_r;
    assign bus.out_batch_count = batch_count_r;
endmodule

// File: tb/tb_ref_force_wb_arbiter.sv
// Directed bench for ref_force_wb_arbiter; outputs are sampled on the falling clock edge.
module tb_ref_force_wb_arbiter;
    import md_wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic exp_ovf;

    ref_force_wb_arbiter_if bus ();

    ref_force_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fx(input int lane, input int tag);
        return {8'h40, 8'(tag), 8'h00, 8'(lane)};
    endfunction

    function automatic logic [31:0] fz(input int lane, input int tag);
        return {8'h42, 8'(tag), 8'h11, 8'(lane)};
    endfunction

    function automatic logic [28:0] fid(input int lane, input int tag);
        return {3'(lane), 3'(tag), 3'd5, 20'(lane * 1000 + tag)};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 7'd0;
        bus.in_start_wb = 7'd0;
    endtask

    task automatic set_lane(input int lane, input int tag);
        bus.in_valid[lane]   = 1'b1;
        bus.in_id[lane]      = fid(lane, tag);
        bus.in_force_x[lane] = fx(lane, tag);
        bus.in_force_y[lane] = {8'h41, 8'(tag), 8'h00, 8'(lane)};
        bus.in_force_z[lane] = fz(lane, tag);
    endtask

    task automatic wait_done(input string tag, input int exp_cnt, input int max_c);
        logic found = 1'b0;
        for (int c = 0; c < max_c && !found; c++) begin
            tick();
            if (bus.out_batch_done) found = 1'b1;
        end
        check_eq({tag, "_done"}, 64'(found), 64'd1);
        check_eq({tag, "_count"}, 64'(bus.out_batch_count), 64'(exp_cnt));
        tick();
        check_eq({tag, "_pulse"}, 64'(bus.out_batch_done), 64'd0);
    endtask

    // Drains seven words from lane 'first' upward, stalling word stall_w for stall_len cycles.
    task automatic drain(input string tag, input int first, input int stall_w, input int stall_len, input int dtag);
        int w = 0;
        int stalls = 0;
        int c = 0;
        bus.out_wb_ready = 1'b1;
        while (w < 7 && c < 40) begin
            tick();
            c++;
            if (bus.out_wb_valid) begin
                check_eq({tag, "_lane"}, 64'(bus.out_wb_lane), 64'((first + w) % 7));
                check_eq({tag, "_x"}, 64'(bus.out_wb_force_x), 64'(fx((first + w) % 7, dtag)));
                check_eq({tag, "_id"}, 64'(bus.out_wb_id), 64'(fid((first + w) % 7, dtag)));
                if (w == stall_w && stalls < stall_len) begin
                    bus.out_wb_ready = 1'b0;
                    stalls++;
                end else begin
                    bus.out_wb_ready = 1'b1;
                    w++;
                end
            end
        end
        check_eq({tag, "_cycles"}, 64'(c), 64'(7 + stall_len));
        bus.out_wb_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
`ifdef REF_WB_OVERFLOW_CHECK_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        rst = 1'b1;
        bus.in_id = '0;
        bus.in_force_x = '0;
        bus.in_force_y = '0;
        bus.in_force_z = '0;
        bus.out_wb_ready = 1'b1;
        idle_inputs();
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 64'(bus.out_wb_valid), 64'd0);
        check_eq("rst_x", 64'(bus.out_wb_force_x), 64'd0);
        check_eq("rst_busy", 64'(bus.out_busy), 64'd0);
        check_eq("rst_done", 64'(bus.out_batch_done), 64'd0);
        check_eq("rst_count", 64'(bus.out_batch_count), 64'd0);
        check_eq("rst_ovf", 64'(bus.out_overflow), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single word from lane 2.
        set_lane(2, 1);
        bus.in_force_x[2] = 32'h3F800000;
        bus.in_start_wb   = 7'b0000100;
        tick();
        idle_inputs();
        check_eq("t1_latency", 64'(bus.out_wb_valid), 64'd0);
        check_eq("t1_busy", 64'(bus.out_busy), 64'd1);
        tick();
        check_eq("t1_valid", 64'(bus.out_wb_valid), 64'd1);
        check_eq("t1_lane", 64'(bus.out_wb_lane), 64'd2);
        check_eq("t1_x", 64'(bus.out_wb_force_x), 64'h3F800000);
        check_eq("t1_id", 64'(bus.out_wb_id), 64'(fid(2, 1)));
        wait_done("t1", 1, 6);

        // Reset in the middle of a drain; pointer sits at 3 so lane 3 goes out first.
        bus.out_wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) set_lane(i, 2);
        bus.in_start_wb = 7'b0000001;
        tick();
        idle_inputs();
        tick();
        check_eq("rs_valid", 64'(bus.out_wb_valid), 64'd1);
        check_eq("rs_lane", 64'(bus.out_wb_lane), 64'd3);
        rst = 1'b0;
        #1;
        check_eq("rs_valid_now", 64'(bus.out_wb_valid), 64'd0);
        check_eq("rs_busy_now", 64'(bus.out_busy), 64'd0);
        check_eq("rs_lane_now", 64'(bus.out_wb_lane), 64'd0);
        repeat (2) tick();
        rst = 1'b1;
        bus.out_wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rs_no_done", 64'(bus.out_batch_done), 64'd0);
            check_eq("rs_no_word", 64'(bus.out_wb_valid), 64'd0);
        end

        // All seven lanes at once, from pointer 0.
        for (int i = 0; i < 7; i++) set_lane(i, 3);
        bus.in_start_wb = 7'b1111111;
        tick();
        idle_inputs();
        drain("t2", 0, 7, 0, 3);
        wait_done("t2", 7, 6);

        // Again with a three-cycle stall on word 2; pointer must be back at 0.
        for (int i = 0; i < 7; i++) set_lane(i, 4);
        bus.in_start_wb = 7'b1111111;
        tick();
        idle_inputs();
        drain("t3", 0, 2, 3, 4);
        wait_done("t3", 7, 6);

        // Capture and grant on lane 5 at the same edge: both values go out, no overflow.
        set_lane(5, 5);
        bus.in_start_wb = 7'b0100000;
        tick();
        idle_inputs();
        set_lane(5, 6);
        tick();
        idle_inputs();
        check_eq("t4_lane_a", 64'(bus.out_wb_lane), 64'd5);
        check_eq("t4_x_a", 64'(bus.out_wb_force_x), 64'(fx(5, 5)));
        tick();
        check_eq("t4_valid_b", 64'(bus.out_wb_valid), 64'd1);
        check_eq("t4_x_b", 64'(bus.out_wb_force_x), 64'(fx(5, 6)));
        wait_done("t4", 2, 6);
        check_eq("t4_no_ovf", 64'(bus.out_overflow), 64'd0);

        // Lane 4 written twice while pending behind a stalled lane 3 word.
        bus.out_wb_ready = 1'b0;
        set_lane(3, 7);
        bus.in_start_wb = 7'b0001000;
        tick();
        idle_inputs();
        set_lane(4, 8);
        tick();
        idle_inputs();
        set_lane(4, 9);
        tick();
        idle_inputs();
        check_eq("t5_lane_a", 64'(bus.out_wb_lane), 64'd3);
        check_eq("t5_z_a", 64'(bus.out_wb_force_z), 64'(fz(3, 7)));
        check_eq("t5_ovf", 64'(bus.out_overflow), 64'(exp_ovf));
        bus.out_wb_ready = 1'b1;
        tick();
        check_eq("t5_lane_b", 64'(bus.out_wb_lane), 64'd4);
        check_eq("t5_x_b", 64'(bus.out_wb_force_x), 64'(fx(4, 9)));
        tick();
        wait_done("t5", 2, 6);
        check_eq("t5_ovf_sticky", 64'(bus.out_overflow), 64'(exp_ovf));

        // Empty batch.
        bus.in_start_wb = 7'b0000001;
        tick();
        idle_inputs();
        wait_done("t6", 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ref_force_wb_arbiter.md
# ref_force_wb_arbiter

Collects the accumulated reference-particle forces produced by the seven partial force accumulators (ACC_ID 0-6) of one RL-LJ evaluation unit and serialises them onto a single force-cache writeback port. Each accumulator lane has a one-deep holding slot. A round-robin arbiter drains pending slots through a registered valid/ready output, and the block reports per-batch completion. It sits between the accumulator bank and the force cache write interface.

## Interface
- DATA_WIDTH, 32, IEEE-754 single-precision force component width
- PARTICLE_ID_WIDTH, 20, particle index field width
- CELL_ID_WIDTH, 3, per-axis cell ID width
- NUM_ACC, 7, number of accumulator lanes (fixed at 7; other values are unsupported)
- ID_WIDTH, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH, full ID: {cell_id x,y,z, particle}
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- in_valid  in  NUM_ACC  per-lane accumulated-force valid (one-cycle pulse)
- in_start_wb  in  NUM_ACC  per-lane writeback-start pulse from the accumulators
- in_id  in  NUM_ACC×ID_WIDTH  per-lane full particle ID
- in_force_x / in_force_y / in_force_z  in  NUM_ACC×DATA_WIDTH each  per-lane accumulated force
- out_wb_valid  out  1  writeback word valid
- out_wb_ready  in  1  force cache accepts the word
- out_wb_id  out  ID_WIDTH  ID of the word
- out_wb_force_x / y / z  out  DATA_WIDTH each  force of the word
- out_wb_lane  out  3  source lane of the word
- out_busy  out  1  any slot pending or out_wb_valid high
- out_batch_done  out  1  one-cycle pulse when a batch has fully drained
- out_batch_count  out  3  number of words written in the finished batch; valid with out_batch_done
- out_overflow  out  1  sticky overflow error

## Operation
- Slot i captures in_id, in_force_x/y/z and sets pending[i] on any cycle where in_valid[i]=1.
- Arbiter: round-robin over the pending slots, searching from pointer rr_ptr. After lane i is granted, rr_ptr becomes (i+1) mod 7.
- A grant occurs when out_wb_valid=0, or when out_wb_valid&out_wb_ready=1. Throughput is 1 word per cycle.
- On a grant, the slot contents load into the output register and pending[grant] clears.
- Output stability: while out_wb_valid=1 and out_wb_ready=0, all out_wb_* fields are held stable.
- Same-edge capture and grant on one lane: the new value is captured and pending stays 1. This is not an overflow.
- Overflow: in_valid[i]=1 while pending[i]=1 and the slot is not being granted.
  - The new value overwrites the slot.
  - out_overflow is set and held until reset.
- Batch FSM states:
  - IDLE: any in_start_wb bit moves the FSM to ACTIVE and clears batch_cnt.
  - ACTIVE: batch_cnt increments on each out_wb_valid&out_wb_ready handshake (saturates at 7).
  - ACTIVE → DONE: no slot pending, out_wb_valid=0, and no in_valid asserted this cycle.
  - DONE: out_batch_done=1 and out_batch_count=batch_cnt for one cycle, then IDLE.
- in_start_wb asserted during ACTIVE or DONE: ignored; the batch extends.
- A batch with zero valid lanes completes with out_batch_count=0. This covers reference particles that have no valid lanes.
- Reset values: out_wb_valid=0, all out_wb_* data=0, out_busy=0, out_batch_done=0, out_batch_count=0, out_overflow=0, pending=0, rr_ptr=0, FSM in IDLE.
- Reset asserted mid-operation discards all pending slots and the output word immediately.

## Timing
- in_valid[i] at edge k: slot captured at edge k. The earliest out_wb_valid is after edge k+1.
- Seven simultaneous valids with out_wb_ready tied to 1: words appear on 7 consecutive cycles in lane order starting at rr_ptr.
- out_batch_done asserts the cycle after the last handshake.
- out_busy is combinational from registered state.
- Reset deassertion is synchronised externally. The block samples inputs from the first rising edge after rst goes high.

## Configuration
- REF_WB_OVERFLOW_CHECK_EN defined: overflow detection and sticky out_overflow are as described above.
- REF_WB_OVERFLOW_CHECK_EN undefined: the detection logic is removed, out_overflow is tied to 0, and overwrite behaviour is unchanged.

## Structure
- Package md_wb_pkg holds:
  - full_id_t (cell_id, particle)
  - force_vec_t {x,y,z}
  - NUM_ACC
  - the CELL_1/2/3 encodings
  - the batch FSM enum
- Sub-module wb_rr_arbiter has request[6:0], advance and pointer state, and outputs a one-hot grant plus an encoded index.

## Test plan
- in_valid=7'b0000100, lane 2 force x=0x3F800000, out_wb_ready=1 → one word with out_wb_lane=2 and x=0x3F800000 after edge k+1; out_batch_done with out_batch_count=1.
- All 7 lanes valid at once, ready=1 → lanes 0..6 on 7 consecutive cycles; out_batch_count=7; rr_ptr=0 afterwards.
- Same as the previous scenario with ready low for 3 cycles at word 2 → word 2 held stable for 3 cycles; order and count unchanged.
- Lane 4 valid twice while its slot is still pending → second value written; out_overflow=1 with the macro defined, 0 without it.
- in_start_wb pulse with no in_valid → out_batch_done within 2 cycles, out_batch_count=0.
- rst driven low mid-drain with 4 pending → out_wb_valid=0 and out_busy=0 immediately; no out_batch_done.
